// File: rtl/fetch_pc_if.sv
// Fetch front-end bundle: execute-stage redirects, hazard stall, instruction memory
// port and the IF/ID pipeline register outputs.
interface fetch_pc_if #(
   parameter int unsigned PC_W   = 13,
   parameter int unsigned INST_W = 16
);
   logic              stall;
   logic              br_taken;
   logic [5:0]        br_offset;
   logic              jmp;
   logic [11:0]       jmp_target;
   logic              jr;
   logic [15:0]       jr_addr;
   logic [PC_W-1:0]   ex_pc;
   logic [INST_W-1:0] inst_in;
   logic [PC_W-1:0]   pc_pointer;
   logic              imem_en;
   logic              ifid_valid;
   logic [INST_W-1:0] ifid_inst;
   logic [PC_W-1:0]   ifid_pc;
   logic [PC_W-1:0]   ifid_pc_plus1;
   logic              halted;

   // Pipeline / memory side that feeds the fetch unit.
   modport master (
      output stall, br_taken, br_offset, jmp, jmp_target, jr, jr_addr, ex_pc, inst_in,
      input  pc_pointer, imem_en, ifid_valid, ifid_inst, ifid_pc, ifid_pc_plus1, halted
   );

   modport slave (
      input  stall, br_taken, br_offset, jmp, jmp_target, jr, jr_addr, ex_pc, inst_in,
      output pc_pointer, imem_en, ifid_valid, ifid_inst, ifid_pc, ifid_pc_plus1, halted
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// MIPS16 instruction-fetch front end: PC, redirects, stall, end-of-program halt and the
// IF/ID register. Instruction memory is registered, so each issued PC is tagged in flight.
module fetch_pc_unit #(
   parameter int unsigned PC_W      = 13,
   parameter int unsigned INST_W    = 16,
   parameter int unsigned RESET_PC  = 0,
   parameter int unsigned MEM_DEPTH = 24
) (
   input logic       clk,
   input logic       rst,
   fetch_pc_if.slave bus
);
   localparam logic [PC_W-1:0] LAST_PC = PC_W'(MEM_DEPTH - 1);

   typedef enum logic [0:0] {StRun, StHalt} state_e;

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q;
   logic              infl_valid_q;
   logic [PC_W-1:0]   infl_pc_q;
   logic              ifid_valid_q;
   logic [INST_W-1:0] ifid_inst_q;
   logic [PC_W-1:0]   ifid_pc_q;
   logic [PC_W-1:0]   ifid_pc_plus1_q;

   logic              redirect;
   logic [PC_W-1:0]   ex_pc_plus1;
   logic [PC_W-1:0]   br_off_ext;
   logic [PC_W-1:0]   target;

   assign redirect    = bus.jr | bus.jmp | bus.br_taken;
   assign ex_pc_plus1 = bus.ex_pc + PC_W'(1);
   assign br_off_ext  = {{(PC_W-6){bus.br_offset[5]}}, bus.br_offset};

   always_comb begin
      target = ex_pc_plus1 + br_off_ext;
      if (bus.jr) begin
         target = bus.jr_addr[PC_W-1:0];
      end else if (bus.jmp) begin
         // Pseudo-direct: top PC bit comes from the jump's own PC+1.
         target = {ex_pc_plus1[PC_W-1], bus.jmp_target};
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      if (redirect) begin
         state_d = StRun;
      end else if (!bus.stall && state_q == StRun && pc_q == LAST_PC) begin
         state_d = StHalt;
      end
   end

   // FSM outputs
   always_comb begin
      bus.imem_en = redirect | (state_q == StRun && !bus.stall);
      bus.halted  = (state_q == StHalt);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q            <= PC_W'(RESET_PC);
         infl_valid_q    <= 1'b0;
         infl_pc_q       <= '0;
         ifid_valid_q    <= 1'b0;
         ifid_inst_q     <= '0;
         ifid_pc_q       <= '0;
         ifid_pc_plus1_q <= '0;
      end else if (redirect) begin
         pc_q         <= target;
         infl_valid_q <= 1'b0;
         ifid_valid_q <= 1'b0;
      end else if (!bus.stall) begin
         ifid_valid_q    <= infl_valid_q;
         ifid_inst_q     <= bus.inst_in;
         ifid_pc_q       <= infl_pc_q;
         ifid_pc_plus1_q <= infl_pc_q + PC_W'(1);
         if (state_q == StRun) begin
            infl_valid_q <= 1'b1;
            infl_pc_q    <= pc_q;
            if (pc_q != LAST_PC) begin
               pc_q <= pc_q + PC_W'(1);
            end
         end else begin
            // Halted: drain the last in-flight word, issue nothing new.
            infl_valid_q <= 1'b0;
         end
      end
   end

   assign bus.pc_pointer    = pc_q;
   assign bus.ifid_valid    = ifid_valid_q;
   assign bus.ifid_inst     = ifid_inst_q;
   assign bus.ifid_pc       = ifid_pc_q;
   assign bus.ifid_pc_plus1 = ifid_pc_plus1_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: vector table for streaming/stall/redirects, plus
// hand sequences for end-of-program halt, jump-bit wrap and reset during stall.
module tb_fetch_pc_unit;
   logic clk = 1'b0;
   logic rst;
   int   n_pass  = 0;
   int   n_total = 0;

   fetch_pc_if #(.PC_W(13), .INST_W(16)) bus ();

   fetch_pc_unit #(
      .PC_W(13), .INST_W(16), .RESET_PC(0), .MEM_DEPTH(24)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [12:0] a);
      return {3'b101, a} ^ 16'h0F0F;
   endfunction

   // Registered instruction memory; holds its output when not enabled.
   initial bus.inst_in = 16'h0000;
   always @(posedge clk) begin
      if (bus.imem_en) bus.inst_in <= mem_word(bus.pc_pointer);
   end

   typedef struct {
      logic        stall, br, jmp, jr;
      logic [5:0]  off;
      logic [11:0] jt;
      logic [15:0] jra;
      logic [12:0] expc;
      logic [12:0] e_pc;
      logic        e_en, e_v;
      logic [12:0] e_ifpc;
   } vec_t;

   vec_t vecs [25];

   function automatic vec_t row(input logic [12:0] pc, input logic en, input logic v,
                                input logic [12:0] ifpc);
      vec_t r;
      r.stall = 1'b0; r.br = 1'b0; r.jmp = 1'b0; r.jr = 1'b0;
      r.off = 6'd0; r.jt = 12'd0; r.jra = 16'd0; r.expc = 13'd0;
      r.e_pc = pc; r.e_en = en; r.e_v = v; r.e_ifpc = ifpc;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   task automatic check_state(input string tag, input logic [12:0] pc, input logic en,
                              input logic v, input logic [12:0] ifpc, input logic h);
      check({tag, " pc_pointer"}, 32'(bus.pc_pointer), 32'(pc));
      check({tag, " imem_en"}, 32'(bus.imem_en), 32'(en));
      check({tag, " ifid_valid"}, 32'(bus.ifid_valid), 32'(v));
      check({tag, " halted"}, 32'(bus.halted), 32'(h));
      if (v) begin
         check({tag, " ifid_pc"}, 32'(bus.ifid_pc), 32'(ifpc));
         check({tag, " ifid_pc_plus1"}, 32'(bus.ifid_pc_plus1), 32'(ifpc + 13'd1));
         check({tag, " ifid_inst"}, 32'(bus.ifid_inst), 32'(mem_word(ifpc)));
      end
   endtask

   task automatic idle_inputs();
      bus.stall = 1'b0; bus.br_taken = 1'b0; bus.jmp = 1'b0; bus.jr = 1'b0;
      bus.br_offset = 6'd0; bus.jmp_target = 12'd0; bus.jr_addr = 16'd0; bus.ex_pc = 13'd0;
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   logic [12:0] h_pc   [7] = '{13'd21, 13'd22, 13'd23, 13'd23, 13'd23, 13'd23, 13'd23};
   logic        h_en   [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   logic        h_v    [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic [12:0] h_ifpc [7] = '{13'd0, 13'd20, 13'd21, 13'd22, 13'd23, 13'd0, 13'd0};
   logic        h_h    [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

   initial begin
      vecs[0]  = row(13'd0,  1'b1, 1'b0, 13'd0);
      vecs[1]  = row(13'd1,  1'b1, 1'b0, 13'd0);
      vecs[2]  = row(13'd2,  1'b1, 1'b1, 13'd0);
      vecs[3]  = row(13'd3,  1'b1, 1'b1, 13'd1);
      vecs[4]  = row(13'd4,  1'b1, 1'b1, 13'd2);
      vecs[5]  = row(13'd5,  1'b0, 1'b1, 13'd3);  vecs[5].stall = 1'b1;
      vecs[6]  = row(13'd5,  1'b0, 1'b1, 13'd3);  vecs[6].stall = 1'b1;
      vecs[7]  = row(13'd5,  1'b0, 1'b1, 13'd3);  vecs[7].stall = 1'b1;
      vecs[8]  = row(13'd5,  1'b1, 1'b1, 13'd3);
      vecs[9]  = row(13'd6,  1'b1, 1'b1, 13'd4);
      vecs[10] = row(13'd7,  1'b1, 1'b1, 13'd5);
      vecs[11] = row(13'd8,  1'b1, 1'b1, 13'd6);
      vecs[11].br = 1'b1; vecs[11].expc = 13'd4; vecs[11].off = 6'd2;
      vecs[12] = row(13'd7,  1'b1, 1'b0, 13'd0);
      vecs[13] = row(13'd8,  1'b1, 1'b0, 13'd0);
      vecs[14] = row(13'd9,  1'b1, 1'b1, 13'd7);
      vecs[14].br = 1'b1; vecs[14].expc = 13'd5; vecs[14].off = 6'b111101;
      vecs[15] = row(13'd3,  1'b1, 1'b0, 13'd0);
      vecs[16] = row(13'd4,  1'b1, 1'b0, 13'd0);
      vecs[17] = row(13'd5,  1'b1, 1'b1, 13'd3);
      vecs[17].jmp = 1'b1; vecs[17].jt = 12'd13; vecs[17].expc = 13'd9;
      vecs[18] = row(13'd13, 1'b1, 1'b0, 13'd0);
      vecs[19] = row(13'd14, 1'b1, 1'b0, 13'd0);
      vecs[20] = row(13'd15, 1'b1, 1'b1, 13'd13);
      vecs[20].jr = 1'b1; vecs[20].jra = 16'h000A; vecs[20].jmp = 1'b1; vecs[20].jt = 12'd20;
      vecs[21] = row(13'd10, 1'b1, 1'b0, 13'd0);
      vecs[21].stall = 1'b1; vecs[21].jmp = 1'b1; vecs[21].jt = 12'd2;
      vecs[22] = row(13'd2,  1'b1, 1'b0, 13'd0);
      vecs[23] = row(13'd3,  1'b1, 1'b0, 13'd0);
      vecs[24] = row(13'd4,  1'b1, 1'b1, 13'd2);

      idle_inputs();
      rst = 1'b1;
      edge_step();
      rst = 1'b0;

      for (int i = 0; i < 25; i++) begin
         bus.stall = vecs[i].stall; bus.br_taken = vecs[i].br;
         bus.jmp = vecs[i].jmp; bus.jr = vecs[i].jr;
         bus.br_offset = vecs[i].off; bus.jmp_target = vecs[i].jt;
         bus.jr_addr = vecs[i].jra; bus.ex_pc = vecs[i].expc;
         #1;
         check_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_en, vecs[i].e_v,
                     vecs[i].e_ifpc, 1'b0);
         edge_step();
      end

      // Run off the end of the program from address 20.
      idle_inputs();
      bus.jmp = 1'b1; bus.jmp_target = 12'd20;
      edge_step();
      idle_inputs();
      #1;
      check_state("halt0", 13'd20, 1'b1, 1'b0, 13'd0, 1'b0);
      for (int k = 0; k < 7; k++) begin
         edge_step();
         check_state($sformatf("halt%0d", k + 1), h_pc[k], h_en[k], h_v[k], h_ifpc[k], h_h[k]);
      end

      // Redirect out of HALT.
      bus.jmp = 1'b1; bus.jmp_target = 12'd0; bus.ex_pc = 13'd0;
      #1;
      check("halt redirect imem_en", 32'(bus.imem_en), 32'd1);
      edge_step();
      idle_inputs();
      #1;
      check_state("unhalt", 13'd0, 1'b1, 1'b0, 13'd0, 1'b0);

      // Jump keeps the top bit of ex_pc+1.
      bus.jmp = 1'b1; bus.jmp_target = 12'd5; bus.ex_pc = 13'h1000;
      edge_step();
      idle_inputs();
      #1;
      check("jmp hi bit pc_pointer", 32'(bus.pc_pointer), 32'h1005);

      // Reset wins over stall.
      bus.stall = 1'b1;
      edge_step();
      check("stall hold pc_pointer", 32'(bus.pc_pointer), 32'h1005);
      rst = 1'b1;
      edge_step();
      rst = 1'b0;
      #1;
      check_state("rst_in_stall", 13'd0, 1'b0, 1'b0, 13'd0, 1'b0);
      bus.stall = 1'b0;
      edge_step();
      check_state("post_rst", 13'd1, 1'b1, 1'b0, 13'd0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
